// File: rtl/l1_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_types
//   Shared types and defaults for the L1 -> L2 arbiter slice.
//   - DEFAULT_ADDR_W / DEFAULT_LINE_W : default byte-address and line widths
//   - arb_state_t : arbiter FSM states (IDLE, SERVE_I, SERVE_D)
//   - side_t      : which L1 was granted most recently (SIDE_I, SIDE_D)
//   - pick_d      : tie-break helper, true when the D side wins a grant
// -----------------------------------------------------------------------------
package arb_types;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } side_t;

    // D wins when it is the only requester, when D priority is strapped on,
    // or on a tie where I was the side served last (round-robin).
    function automatic logic pick_d(
        input logic  req_i,
        input logic  req_d,
        input side_t last_served,
        input logic  d_priority
    );
        return req_d && (!req_i || d_priority || (last_served == SIDE_I));
    endfunction

endpackage

// File: rtl/l1_arbiter_req_reg.sv
// -----------------------------------------------------------------------------
// l1_arbiter_req_reg
//   Request register holding the granted L1 request for the duration of the
//   L2 transaction, so L2 never sees the live (possibly changing) L1 inputs.
//
// Ports:
//   clk           in   clock, rising edge
//   clear         in   synchronous clear, active high (wins over load)
//   load          in   capture load_* on this edge
//   load_address  in   ADDR_W  address of the granted request
//   load_wdata    in   LINE_W  writeback line of the granted request
//   load_write    in   1 = writeback, 0 = line read
//   address       out  ADDR_W  latched address
//   wdata         out  LINE_W  latched write line
//   write         out  latched op
// -----------------------------------------------------------------------------
module l1_arbiter_req_reg
    import arb_types::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LINE_W = DEFAULT_LINE_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_address,
    input  logic [LINE_W-1:0] load_wdata,
    input  logic              load_write,
    output logic [ADDR_W-1:0] address,
    output logic [LINE_W-1:0] wdata,
    output logic              write
);

    always_ff @(posedge clk) begin
        if (clear) begin
            address <= '0;
            wdata   <= '0;
            write   <= 1'b0;
        end else if (load) begin
            address <= load_address;
            wdata   <= load_wdata;
            write   <= load_write;
        end
    end

endmodule

// File: rtl/l1_arbiter.sv
// -----------------------------------------------------------------------------
// l1_arbiter
//   Arbitrates one outstanding line request from each of the split L1 I and D
//   caches onto the shared L2 path, one transaction at a time. The granted
//   request is latched and held on L2 until l2_resp; the response is steered
//   back as a one-cycle i_resp / d_resp pulse.
//
// Parameters:
//   ADDR_W      byte address width
//   LINE_W      cache line width in bits
//   D_PRIORITY  0 = round-robin between I and D, 1 = D wins every tie
//
// Ports:
//   clk, reset                         clock; synchronous active-low reset
//   i_read, i_address                  I-cache line read request (level)
//   i_rdata, i_resp                    I-cache read data / completion pulse
//   d_read, d_write, d_address, d_wdata D-cache read or writeback request
//   d_rdata, d_resp                    D-cache read data / completion pulse
//   l2_read, l2_write                  request to L2, held until l2_resp
//   l2_address, l2_wdata               latched address / write line to L2
//   l2_rdata, l2_resp                  L2 read data and completion pulse
// -----------------------------------------------------------------------------
module l1_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int LINE_W     = DEFAULT_LINE_W,
    parameter int D_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t        state;
    side_t             last_served;

    logic              req_i;
    logic              req_d;
    logic              grant_d;
    logic              load;
    logic [ADDR_W-1:0] load_address;
    logic [LINE_W-1:0] load_wdata;
    logic              load_write;
    logic              op_write;
    logic              serving;

    // Request decode and tie-break. d_read and d_write together is treated
    // as a writeback because load_write follows d_write alone.
    always_comb begin
        req_i        = i_read;
        req_d        = d_read | d_write;
        grant_d      = pick_d(req_i, req_d, last_served, D_PRIORITY != 0);
        load         = (state == IDLE) && (req_i || req_d);
        load_address = grant_d ? d_address : i_address;
        load_wdata   = grant_d ? d_wdata   : '0;
        load_write   = grant_d && d_write;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= SIDE_D;
        end else begin
            case (state)
                IDLE: begin
                    // l2_resp seen here is a stray and is deliberately ignored.
                    if (load) begin
                        state       <= grant_d ? SERVE_D : SERVE_I;
                        last_served <= grant_d ? SIDE_D  : SIDE_I;
                    end
                end
                SERVE_I,
                SERVE_D: begin
                    if (l2_resp) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    l1_arbiter_req_reg #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_reg (
        .clk          (clk),
        .clear        (!reset),
        .load         (load),
        .load_address (load_address),
        .load_wdata   (load_wdata),
        .load_write   (load_write),
        .address      (l2_address),
        .wdata        (l2_wdata),
        .write        (op_write)
    );

    always_comb begin
        serving  = (state == SERVE_I) || (state == SERVE_D);
        l2_read  = serving && !op_write;
        l2_write = serving && op_write;
    end

    // Zero-latency steering. The pulse is withheld when the served L1 has
    // already withdrawn (abort) and while reset is asserted, so an in-flight
    // response that races reset is dropped.
    always_comb begin
        i_resp  = reset && l2_resp && (state == SERVE_I) && i_read;
        d_resp  = reset && l2_resp && (state == SERVE_D) && (d_read || d_write);
        i_rdata = l2_rdata;
        d_rdata = l2_rdata;
    end

endmodule

// File: tb/tb_l1_arbiter.sv
module tb_l1_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          i_read    [2];
    logic [AW-1:0] i_address [2];
    logic [LW-1:0] i_rdata   [2];
    logic          i_resp    [2];
    logic          d_read    [2];
    logic          d_write   [2];
    logic [AW-1:0] d_address [2];
    logic [LW-1:0] d_wdata   [2];
    logic [LW-1:0] d_rdata   [2];
    logic          d_resp    [2];
    logic          l2_read   [2];
    logic          l2_write  [2];
    logic [AW-1:0] l2_address[2];
    logic [LW-1:0] l2_wdata  [2];
    logic [LW-1:0] l2_rdata  [2];
    logic          l2_resp   [2];

    // Instance 0: round-robin. Instance 1: D priority.
    l1_arbiter #(.ADDR_W(AW), .LINE_W(LW), .D_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(rst_n),
        .i_read(i_read[0]), .i_address(i_address[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
        .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
        .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_address(l2_address[0]),
        .l2_wdata(l2_wdata[0]), .l2_rdata(l2_rdata[0]), .l2_resp(l2_resp[0])
    );

    l1_arbiter #(.ADDR_W(AW), .LINE_W(LW), .D_PRIORITY(1)) dut_dp (
        .clk(clk), .reset(rst_n),
        .i_read(i_read[1]), .i_address(i_address[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
        .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
        .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_address(l2_address[1]),
        .l2_wdata(l2_wdata[1]), .l2_rdata(l2_rdata[1]), .l2_resp(l2_resp[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One record per instance: is a transaction open, which side owns it,
    // what L2 must see, and who was granted last.
    logic          m_valid = 1'b0;
    logic          m_busy  [2];
    logic          m_d     [2];
    logic          m_wr    [2];
    logic          m_last_d[2];
    logic [AW-1:0] m_addr  [2];
    logic [LW-1:0] m_wdata [2];

    function automatic logic winner_is_d(input logic want_i, input logic want_d,
                                         input logic last_d, input int k);
        if (want_i && want_d) return (k == 1) ? 1'b1 : !last_d;
        return want_d;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k]   <= 1'b0;
                m_d[k]      <= 1'b0;
                m_wr[k]     <= 1'b0;
                m_last_d[k] <= 1'b1;
                m_addr[k]   <= '0;
                m_wdata[k]  <= '0;
            end else if (m_busy[k]) begin
                if (l2_resp[k]) m_busy[k] <= 1'b0;
            end else if (i_read[k] || d_read[k] || d_write[k]) begin
                m_busy[k]   <= 1'b1;
                m_d[k]      <= winner_is_d(i_read[k], d_read[k] | d_write[k], m_last_d[k], k);
                m_last_d[k] <= winner_is_d(i_read[k], d_read[k] | d_write[k], m_last_d[k], k);
                m_addr[k]   <= winner_is_d(i_read[k], d_read[k] | d_write[k], m_last_d[k], k)
                               ? d_address[k] : i_address[k];
                m_wr[k]     <= winner_is_d(i_read[k], d_read[k] | d_write[k], m_last_d[k], k)
                               && d_write[k];
                m_wdata[k]  <= d_wdata[k];
            end
        end
        if (!rst_n) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc_l2_read[%0d]", k),  l2_read[k],  m_busy[k] && !m_wr[k]);
                check($sformatf("cyc_l2_write[%0d]", k), l2_write[k], m_busy[k] && m_wr[k]);
                check($sformatf("cyc_i_resp[%0d]", k), i_resp[k],
                      rst_n && m_busy[k] && !m_d[k] && l2_resp[k] && i_read[k]);
                check($sformatf("cyc_d_resp[%0d]", k), d_resp[k],
                      rst_n && m_busy[k] && m_d[k] && l2_resp[k] && (d_read[k] || d_write[k]));
                check($sformatf("cyc_i_rdata[%0d]", k), i_rdata[k], l2_rdata[k]);
                check($sformatf("cyc_d_rdata[%0d]", k), d_rdata[k], l2_rdata[k]);
                if (m_busy[k])
                    check($sformatf("cyc_l2_address[%0d]", k), l2_address[k], m_addr[k]);
                if (m_busy[k] && m_wr[k])
                    check($sformatf("cyc_l2_wdata[%0d]", k), l2_wdata[k], m_wdata[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_side(input int k, input bit side_d);
        if (side_d) begin
            d_read[k]  = 1'b0;
            d_write[k] = 1'b0;
        end else begin
            i_read[k] = 1'b0;
        end
    endtask

    // Waits for the grant, checks the latched request, lets L2 answer after
    // lat cycles in the serve state, checks the steered response, then the
    // served L1 withdraws on the following cycle.
    task automatic serve(input int k, input int lat, input logic [AW-1:0] exp_addr,
                         input bit exp_d, input bit exp_wr, input logic [LW-1:0] exp_wdata,
                         input logic [LW-1:0] rdata, input bit abort, input string tag);
        int n;
        n = 0;
        while (!(l2_read[k] || l2_write[k]) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_grant_latency"}, n, 1);
        check({tag, "_addr"},  l2_address[k], exp_addr);
        check({tag, "_write"}, l2_write[k], exp_wr);
        if (exp_wr) check({tag, "_wdata"}, l2_wdata[k], exp_wdata);
        // Live inputs move while waiting; L2 must keep the latched values.
        if (exp_d) begin
            d_address[k] = d_address[k] ^ 32'h0000_7000;
            d_wdata[k]   = ~d_wdata[k];
        end else begin
            i_address[k] = i_address[k] ^ 32'h0000_7000;
        end
        if (abort) drop_side(k, exp_d);
        repeat (lat - 1) tick();
        l2_rdata[k] = rdata;
        l2_resp[k]  = 1'b1;
        @(negedge clk);
        check({tag, "_l2_held"}, l2_read[k] || l2_write[k], 1'b1);
        check({tag, "_resp"},  exp_d ? d_resp[k] : i_resp[k], !abort);
        check({tag, "_other_resp"}, exp_d ? i_resp[k] : d_resp[k], 1'b0);
        check({tag, "_rdata"}, exp_d ? d_rdata[k] : i_rdata[k], rdata);
        check({tag, "_addr_at_resp"}, l2_address[k], exp_addr);
        tick();
        l2_resp[k] = 1'b0;
        drop_side(k, exp_d);
        @(negedge clk);
        check({tag, "_idle_after"}, l2_read[k] || l2_write[k], 1'b0);
    endtask

    task automatic tie(input int k, input bit first_d, input string tag);
        tick();
        i_read[k]    = 1'b1;
        i_address[k] = 32'h0000_1040;
        d_read[k]    = 1'b1;
        d_address[k] = 32'h0000_2080;
        if (first_d) begin
            serve(k, 2, 32'h0000_2080, 1'b1, 1'b0, '0, {8{32'hDDDD_0001}}, 1'b0, {tag, "_1st_D"});
            serve(k, 2, 32'h0000_1040, 1'b0, 1'b0, '0, {8{32'h1111_0002}}, 1'b0, {tag, "_2nd_I"});
        end else begin
            serve(k, 2, 32'h0000_1040, 1'b0, 1'b0, '0, {8{32'h1111_0001}}, 1'b0, {tag, "_1st_I"});
            serve(k, 2, 32'h0000_2080, 1'b1, 1'b0, '0, {8{32'hDDDD_0002}}, 1'b0, {tag, "_2nd_D"});
        end
    endtask

    task automatic stray_resp(input int k, input string tag);
        tick();
        l2_rdata[k] = {8{32'hBAD0_BAD0}};
        l2_resp[k]  = 1'b1;
        @(negedge clk);
        check({tag, "_i_resp"}, i_resp[k], 1'b0);
        check({tag, "_d_resp"}, d_resp[k], 1'b0);
        tick();
        l2_resp[k] = 1'b0;
        @(negedge clk);
        check({tag, "_still_idle"}, l2_read[k] || l2_write[k], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_read[k] = 1'b0;   i_address[k] = '0;
            d_read[k] = 1'b0;   d_write[k]   = 1'b0;
            d_address[k] = '0;  d_wdata[k]   = '0;
            l2_rdata[k] = '0;   l2_resp[k]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_l2_read[%0d]", k),    l2_read[k],    1'b0);
            check($sformatf("reset_l2_write[%0d]", k),   l2_write[k],   1'b0);
            check($sformatf("reset_l2_address[%0d]", k), l2_address[k], 32'h0);
            check($sformatf("reset_l2_wdata[%0d]", k),   l2_wdata[k],   '0);
            check($sformatf("reset_i_resp[%0d]", k),     i_resp[k],     1'b0);
            check($sformatf("reset_d_resp[%0d]", k),     d_resp[k],     1'b0);
        end
        tick();
        rst_n = 1'b1;

        // Round-robin instance: after reset I wins, then D; last served is D
        // again after that pair, so I wins the next tie as well.
        tie(0, 1'b0, "rr_tie_after_reset");
        tie(0, 1'b0, "rr_tie_after_d");

        // Lone I read; leaves I as last served so the next tie goes to D.
        tick();
        i_read[0]    = 1'b1;
        i_address[0] = 32'h0000_1040;
        serve(0, 2, 32'h0000_1040, 1'b0, 1'b0, '0, {32{8'hA5}}, 1'b0, "rr_lone_i");
        tie(0, 1'b1, "rr_tie_after_i");

        // D writeback with the live address moved to 0x4000 mid-transaction.
        tick();
        d_write[0]   = 1'b1;
        d_address[0] = 32'h0000_3000;
        d_wdata[0]   = {16{16'h1234}};
        serve(0, 3, 32'h0000_3000, 1'b1, 1'b1, {16{16'h1234}}, {8{32'hC0DE_0003}}, 1'b0, "rr_d_writeback");

        // Illegal read+write is a writeback.
        tick();
        d_read[0]    = 1'b1;
        d_write[0]   = 1'b1;
        d_address[0] = 32'h0000_6000;
        d_wdata[0]   = {8{32'h6666_0000}};
        serve(0, 2, 32'h0000_6000, 1'b1, 1'b1, {8{32'h6666_0000}}, {8{32'hC0DE_0004}}, 1'b0, "rr_d_rw_both");

        // Abort: I withdraws after grant, L2 answers 5 cycles in.
        tick();
        i_read[0]    = 1'b1;
        i_address[0] = 32'h0000_7040;
        serve(0, 5, 32'h0000_7040, 1'b0, 1'b0, '0, {8{32'hAB0E_0005}}, 1'b1, "rr_abort_i");

        stray_resp(0, "rr_stray_idle");

        // D-priority instance: D first on both ties.
        tie(1, 1'b1, "dp_tie_1");
        tie(1, 1'b1, "dp_tie_2");

        // Reset during SERVE_D on the round-robin instance.
        tick();
        d_read[0]    = 1'b1;
        d_address[0] = 32'h0000_5000;
        tick();
        check("rst_mid_granted", l2_read[0], 1'b1);
        check("rst_mid_addr", l2_address[0], 32'h0000_5000);
        rst_n     = 1'b0;
        d_read[0] = 1'b0;
        tick();
        @(negedge clk);
        check("rst_mid_l2_read",    l2_read[0],    1'b0);
        check("rst_mid_l2_write",   l2_write[0],   1'b0);
        check("rst_mid_l2_address", l2_address[0], 32'h0);
        check("rst_mid_l2_wdata",   l2_wdata[0],   '0);
        check("rst_mid_i_resp",     i_resp[0],     1'b0);
        check("rst_mid_d_resp",     d_resp[0],     1'b0);
        tick();
        rst_n = 1'b1;
        stray_resp(0, "rr_stray_after_reset");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
